ob_mk_matcher: RTL and testbench

OB_MK_MATCHER -- requirements
Module: ob_mk_matcher

---
 rtl/ob_pkg.sv | 19 +
 rtl/ob_mk_qty_cmp.sv | 35 +++
 rtl/ob_mk_matcher.sv | 172 +++++++++++++++++
 tb/tb_ob_mk_matcher.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// Shared types for the market-order matcher.
// trade_kind_e : encoding of the trade_kind_r output (NONE / LB_MS / LS_MB / MB_MS).
// state_e      : matcher FSM states.
package ob_pkg;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_LB_MS = 2'd1,
    KIND_LS_MB = 2'd2,
    KIND_MB_MS = 2'd3
  } trade_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/ob_mk_qty_cmp.sv
// Quantity compare for one buy-side / sell-side order pair.
// qa       : buy-side order quantity
// qb       : sell-side order quantity
// min_qty  : filled quantity, min(qa, qb)
// rsd_qty  : residual left on the larger order, |qa - qb|
// rsd_side : 0 = residual on the buy side (or equal), 1 = on the sell side
module ob_mk_qty_cmp #(
  parameter int QTY_W = 16
) (
  input  logic [QTY_W-1:0] qa,
  input  logic [QTY_W-1:0] qb,
  output logic [QTY_W-1:0] min_qty,
  output logic [QTY_W-1:0] rsd_qty,
  output logic             rsd_side
);

  logic signed [QTY_W:0] diff;

  // Magnitude of a difference of two unsigned QTY_W values; it always fits in
  // QTY_W bits, so the negation is done on the low bits only.
  function automatic logic [QTY_W-1:0] mag(input logic signed [QTY_W:0] d);
    if (d[QTY_W])
      mag = ~d[QTY_W-1:0] + QTY_W'(1);
    else
      mag = d[QTY_W-1:0];
  endfunction

  always_comb begin
    diff     = $signed({1'b0, qa}) - $signed({1'b0, qb});
    rsd_side = diff[QTY_W];
    min_qty  = diff[QTY_W] ? qa : qb;
    rsd_qty  = mag(diff);
  end

endmodule

// File: rtl/ob_mk_matcher.sv
// Market-order matcher: on a query it snapshots the head Limit bid/ask and
// Market buy/sell orders, picks one trade (LB_MS, LS_MB or MB_MS) and
// presents it until the consumer acknowledges it.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   lm_bid_*, lm_ask_*          head Limit bid / ask (valid + quantity)
//   mk_buy_*, mk_sell_*         head Market buy / sell (valid + quantity)
//   trade_qry                   request one evaluation (honoured in IDLE only)
//   trade_ack                   consumer accepts the presented trade
//   busy_r                      state is not IDLE
//   trade_vld_r/kind_r/qty_r    presented trade, its kind and filled quantity
//   trade_rsd_qty_r/rsd_side_r  residual on the larger order and its side
//   nomatch_r                   one-cycle pulse when no pair can trade
module ob_mk_matcher
  import ob_pkg::*;
#(
  parameter int QTY_W      = 16,
  parameter int STARVE_MAX = 4,
  parameter int MODE       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lm_bid_vld_r,
  input  logic [QTY_W-1:0] lm_bid_qty_r,
  input  logic             lm_ask_vld_r,
  input  logic [QTY_W-1:0] lm_ask_qty_r,
  input  logic             mk_buy_vld,
  input  logic [QTY_W-1:0] mk_buy_qty,
  input  logic             mk_sell_vld,
  input  logic [QTY_W-1:0] mk_sell_qty,
  input  logic             trade_qry,
  input  logic             trade_ack,
  output logic             busy_r,
  output logic             trade_vld_r,
  output logic [1:0]       trade_kind_r,
  output logic [QTY_W-1:0] trade_qty_r,
  output logic [QTY_W-1:0] trade_rsd_qty_r,
  output logic             trade_rsd_side_r,
  output logic             nomatch_r
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_e state, state_nx;

  logic             bid_vld_p0, ask_vld_p0, buy_vld_p0, sell_vld_p0;
  logic [QTY_W-1:0] bid_qty_p0, ask_qty_p0, buy_qty_p0, sell_qty_p0;

  logic [CNT_W-1:0] starve_cnt;

  logic [QTY_W-1:0] lbms_min, lbms_rsd, lsmb_min, lsmb_rsd, mbms_min, mbms_rsd;
  logic             lbms_side, lsmb_side, mbms_side;

  logic             c_lbms, c_lsmb, c_mbms, force_mm;
  trade_kind_e      win_kind;
  logic [QTY_W-1:0] win_qty, win_rsd;
  logic             win_side;

  // Stage p0: order snapshot taken on an accepted query
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && trade_qry) begin
      bid_vld_p0  <= lm_bid_vld_r;
      bid_qty_p0  <= lm_bid_qty_r;
      ask_vld_p0  <= lm_ask_vld_r;
      ask_qty_p0  <= lm_ask_qty_r;
      buy_vld_p0  <= mk_buy_vld;
      buy_qty_p0  <= mk_buy_qty;
      sell_vld_p0 <= mk_sell_vld;
      sell_qty_p0 <= mk_sell_qty;
    end
  end

  // Each pair is compared buy-side first so rsd_side means the same for all.
  ob_mk_qty_cmp #(.QTY_W(QTY_W)) u_cmp_lbms (
    .qa(bid_qty_p0), .qb(sell_qty_p0),
    .min_qty(lbms_min), .rsd_qty(lbms_rsd), .rsd_side(lbms_side)
  );

  ob_mk_qty_cmp #(.QTY_W(QTY_W)) u_cmp_lsmb (
    .qa(buy_qty_p0), .qb(ask_qty_p0),
    .min_qty(lsmb_min), .rsd_qty(lsmb_rsd), .rsd_side(lsmb_side)
  );

  ob_mk_qty_cmp #(.QTY_W(QTY_W)) u_cmp_mbms (
    .qa(buy_qty_p0), .qb(sell_qty_p0),
    .min_qty(mbms_min), .rsd_qty(mbms_rsd), .rsd_side(mbms_side)
  );

  // Winner selection; the ageing override lets a starved Market<->Market
  // trade through after STARVE_MAX consecutive Limit-side wins.
  always_comb begin
    c_lbms   = bid_vld_p0 & sell_vld_p0;
    c_lsmb   = ask_vld_p0 & buy_vld_p0;
    c_mbms   = buy_vld_p0 & sell_vld_p0;
    force_mm = (MODE == 1) && (STARVE_MAX > 0) && (starve_cnt == CNT_MAX) && c_mbms;

    win_kind = KIND_NONE;
    if (force_mm)    win_kind = KIND_MB_MS;
    else if (c_lbms) win_kind = KIND_LB_MS;
    else if (c_lsmb) win_kind = KIND_LS_MB;
    else if (c_mbms) win_kind = KIND_MB_MS;

    win_qty  = '0;
    win_rsd  = '0;
    win_side = 1'b0;
    case (win_kind)
      KIND_LB_MS: begin win_qty = lbms_min; win_rsd = lbms_rsd; win_side = lbms_side; end
      KIND_LS_MB: begin win_qty = lsmb_min; win_rsd = lsmb_rsd; win_side = lsmb_side; end
      KIND_MB_MS: begin win_qty = mbms_min; win_rsd = mbms_rsd; win_side = mbms_side; end
      default:    ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (trade_qry) state_nx = ST_EVAL;
      ST_EVAL: state_nx = (win_kind != KIND_NONE) ? ST_PEND : ST_IDLE;
      ST_PEND: if (trade_ack) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Stage p1: trade registers loaded from EVAL, held through PEND
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r           <= 1'b0;
      trade_vld_r      <= 1'b0;
      trade_kind_r     <= KIND_NONE;
      trade_qty_r      <= '0;
      trade_rsd_qty_r  <= '0;
      trade_rsd_side_r <= 1'b0;
      nomatch_r        <= 1'b0;
      starve_cnt       <= '0;
    end else begin
      busy_r    <= (state_nx != ST_IDLE);
      nomatch_r <= 1'b0;
      case (state)
        ST_EVAL: begin
          if (win_kind != KIND_NONE) begin
            trade_vld_r      <= 1'b1;
            trade_kind_r     <= win_kind;
            trade_qty_r      <= win_qty;
            trade_rsd_qty_r  <= win_rsd;
            trade_rsd_side_r <= win_side;
            if (win_kind == KIND_MB_MS)
              starve_cnt <= '0;
            else if (c_mbms && starve_cnt != CNT_MAX)
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else begin
            nomatch_r    <= 1'b1;
            trade_kind_r <= KIND_NONE;
          end
        end
        ST_PEND: begin
          if (trade_ack) begin
            trade_vld_r  <= 1'b0;
            trade_kind_r <= KIND_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ob_mk_matcher.sv
module tb_ob_mk_matcher;
  import ob_pkg::*;

  localparam int QW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bid_vld = 1'b0, ask_vld = 1'b0, buy_vld = 1'b0, sell_vld = 1'b0;
  logic [QW-1:0] bid_qty = '0, ask_qty = '0, buy_qty = '0, sell_qty = '0;
  logic          qry = 1'b0, ack = 1'b0;
  logic          busy, tvld, tside, nomatch;
  logic [1:0]    tkind;
  logic [QW-1:0] tqty, trsd;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ob_mk_matcher #(.QTY_W(QW), .STARVE_MAX(2), .MODE(1)) dut (
    .clk(clk), .rst(rst),
    .lm_bid_vld_r(bid_vld), .lm_bid_qty_r(bid_qty),
    .lm_ask_vld_r(ask_vld), .lm_ask_qty_r(ask_qty),
    .mk_buy_vld(buy_vld), .mk_buy_qty(buy_qty),
    .mk_sell_vld(sell_vld), .mk_sell_qty(sell_qty),
    .trade_qry(qry), .trade_ack(ack),
    .busy_r(busy), .trade_vld_r(tvld), .trade_kind_r(tkind),
    .trade_qty_r(tqty), .trade_rsd_qty_r(trsd), .trade_rsd_side_r(tside),
    .nomatch_r(nomatch)
  );

  typedef struct packed {
    logic          bv; logic [QW-1:0] bq;
    logic          av; logic [QW-1:0] aq;
    logic          uv; logic [QW-1:0] uq;
    logic          sv; logic [QW-1:0] sq;
    logic [1:0]    kind;
    logic [QW-1:0] qty;
    logic [QW-1:0] rsd;
    logic          side;
  } vec_t;

  function automatic vec_t mkv(logic bv, logic [QW-1:0] bq, logic av, logic [QW-1:0] aq,
                               logic uv, logic [QW-1:0] uq, logic sv, logic [QW-1:0] sq,
                               logic [1:0] kind, logic [QW-1:0] qty, logic [QW-1:0] rsd,
                               logic side);
    vec_t v;
    v.bv = bv; v.bq = bq; v.av = av; v.aq = aq;
    v.uv = uv; v.uq = uq; v.sv = sv; v.sq = sq;
    v.kind = kind; v.qty = qty; v.rsd = rsd; v.side = side;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_orders(input vec_t v);
    bid_vld = v.bv; bid_qty = v.bq; ask_vld = v.av; ask_qty = v.aq;
    buy_vld = v.uv; buy_qty = v.uq; sell_vld = v.sv; sell_qty = v.sq;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; qry = 1'b0; ack = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic chk_trade(input string tag, input vec_t v);
    chk({tag, " vld"},  32'(tvld), 32'd1);
    chk({tag, " kind"}, 32'(tkind), 32'(v.kind));
    chk({tag, " qty"},  32'(tqty), 32'(v.qty));
    chk({tag, " rsd"},  32'(trsd), 32'(v.rsd));
    chk({tag, " side"}, 32'(tside), 32'(v.side));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " nomatch"}, 32'(nomatch), 32'd0);
  endtask

  // Full query / evaluate / acknowledge handshake with checks at N+1 and N+2.
  task automatic query_check(input string tag, input vec_t v);
    @(negedge clk); set_orders(v); qry = 1'b1;
    @(negedge clk); qry = 1'b0;
    chk({tag, " n1 busy"}, 32'(busy), 32'd1);
    chk({tag, " n1 vld"},  32'(tvld), 32'd0);
    @(negedge clk);
    if (v.kind != KIND_NONE) begin
      chk_trade(tag, v);
      ack = 1'b1;
      @(negedge clk); ack = 1'b0;
      chk({tag, " post vld"},  32'(tvld), 32'd0);
      chk({tag, " post busy"}, 32'(busy), 32'd0);
    end else begin
      chk({tag, " nm pulse"}, 32'(nomatch), 32'd1);
      chk({tag, " nm vld"},   32'(tvld), 32'd0);
      chk({tag, " nm kind"},  32'(tkind), 32'd0);
      chk({tag, " nm busy"},  32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, " nm end"},   32'(nomatch), 32'd0);
    end
  endtask

  vec_t vecs[11];
  vec_t v_all, v_all_mm;

  initial begin
    vecs[0]  = mkv(1, 100, 0, 0, 1, 10, 1, 40,          KIND_LB_MS, 40, 60, 0);
    vecs[1]  = mkv(0, 0, 0, 0, 1, 16'hFFFF, 1, 1,       KIND_MB_MS, 1, 16'hFFFE, 0);
    vecs[2]  = mkv(0, 0, 1, 50, 1, 70, 0, 0,            KIND_LS_MB, 50, 20, 0);
    vecs[3]  = mkv(0, 0, 1, 90, 1, 30, 0, 0,            KIND_LS_MB, 30, 60, 1);
    vecs[4]  = mkv(1, 5, 0, 0, 0, 0, 1, 5,              KIND_LB_MS, 5, 0, 0);
    vecs[5]  = mkv(1, 10, 1, 20, 1, 30, 1, 40,          KIND_LB_MS, 10, 30, 1);
    vecs[6]  = mkv(0, 0, 1, 7, 1, 3, 1, 9,              KIND_LS_MB, 3, 4, 1);
    vecs[7]  = mkv(0, 0, 1, 33, 0, 0, 0, 0,             KIND_NONE, 0, 0, 0);
    vecs[8]  = mkv(1, 12, 0, 0, 1, 12, 0, 0,            KIND_NONE, 0, 0, 0);
    vecs[9]  = mkv(1, 16'hFFFF, 0, 0, 0, 0, 1, 0,       KIND_LB_MS, 0, 16'hFFFF, 0);
    vecs[10] = mkv(0, 0, 0, 0, 1, 1, 1, 16'hFFFF,       KIND_MB_MS, 1, 16'hFFFE, 1);
    v_all    = vecs[5];
    v_all_mm = mkv(1, 10, 1, 20, 1, 30, 1, 40,          KIND_MB_MS, 30, 10, 1);

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst vld", 32'(tvld), 32'd0);
    chk("rst kind", 32'(tkind), 32'd0);
    chk("rst qty", 32'(tqty), 32'd0);
    chk("rst rsd", 32'(trsd), 32'd0);
    chk("rst side", 32'(tside), 32'd0);
    chk("rst nomatch", 32'(nomatch), 32'd0);

    // Table of single evaluations, each from a clean ageing counter
    for (int i = 0; i < 11; i++) begin
      do_reset();
      query_check($sformatf("vec%0d", i), vecs[i]);
    end

    // Ageing: two Limit wins then the starved Market<->Market trade, then clear
    do_reset();
    query_check("age1", v_all);
    query_check("age2", v_all);
    query_check("age3", v_all_mm);
    query_check("age4", v_all);

    // Hold in PEND with qry toggling and inputs changing
    do_reset();
    @(negedge clk); set_orders(vecs[0]); qry = 1'b1;
    @(negedge clk); qry = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk_trade($sformatf("hold%0d", k), vecs[0]);
      qry = ~qry;
      set_orders(vecs[(k % 3) + 1]);
      @(negedge clk);
    end
    qry = 1'b0; ack = 1'b1;
    chk_trade("hold ack", vecs[0]);
    @(negedge clk); ack = 1'b0;
    chk("hold post vld", 32'(tvld), 32'd0);
    chk("hold post busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("hold no reeval", 32'(busy), 32'd0);

    // ack while EVAL and while IDLE has no effect
    do_reset();
    @(negedge clk); set_orders(vecs[2]); qry = 1'b1;
    @(negedge clk); qry = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    chk_trade("ack in eval", vecs[2]);
    @(negedge clk);
    chk_trade("ack in eval held", vecs[2]);
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    chk("ack idle busy", 32'(busy), 32'd0);
    chk("ack idle vld", 32'(tvld), 32'd0);
    chk("ack idle nomatch", 32'(nomatch), 32'd0);

    // rst with qry in IDLE: reset wins
    @(negedge clk); rst = 1'b1; qry = 1'b1;
    @(negedge clk); rst = 1'b0; qry = 1'b0;
    chk("rst+qry busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst+qry busy2", 32'(busy), 32'd0);
    chk("rst+qry vld", 32'(tvld), 32'd0);
    chk("rst+qry nomatch", 32'(nomatch), 32'd0);

    // rst during EVAL discards the evaluation
    @(negedge clk); set_orders(vecs[0]); qry = 1'b1;
    @(negedge clk); qry = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst eval vld", 32'(tvld), 32'd0);
    chk("rst eval busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst eval vld2", 32'(tvld), 32'd0);
    chk("rst eval nomatch", 32'(nomatch), 32'd0);

    // rst with ack in PEND after one Limit win (counter was 1)
    do_reset();
    @(negedge clk); set_orders(v_all); qry = 1'b1;
    @(negedge clk); qry = 1'b0;
    @(negedge clk);
    chk_trade("pend pre rst", v_all);
    rst = 1'b1; ack = 1'b1; qry = 1'b1;
    @(negedge clk); rst = 1'b0; ack = 1'b0; qry = 1'b0;
    chk("prst busy", 32'(busy), 32'd0);
    chk("prst vld", 32'(tvld), 32'd0);
    chk("prst kind", 32'(tkind), 32'd0);
    chk("prst qty", 32'(tqty), 32'd0);
    chk("prst rsd", 32'(trsd), 32'd0);
    chk("prst side", 32'(tside), 32'd0);
    chk("prst nomatch", 32'(nomatch), 32'd0);
    chk("prst starve_cnt", 32'(dut.starve_cnt), 32'd0);
    query_check("prst age1", v_all);
    query_check("prst age2", v_all);
    query_check("prst age3", v_all_mm);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
